// File: rtl/ifmap_pkg.sv
// ---------------------------------------------------------------------------
// ifmap_pkg
// Shared definitions for the IFmap row framer:
//   - tag constants placed in the two MSBs of every IF buffer word
//   - framer state encoding
//   - tag_of(): tag for word index k inside a frame of n words
// ---------------------------------------------------------------------------
package ifmap_pkg;

    localparam logic [1:0] TAG_FIRST  = 2'b10;
    localparam logic [1:0] TAG_MID    = 2'b00;
    localparam logic [1:0] TAG_LAST   = 2'b01;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    // Index/length width used by tag_of(); callers zero-extend into it.
    localparam int TAG_IDX_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_e;

    // A one-word frame is both first and last, so it gets its own tag.
    function automatic logic [1:0] tag_of(input logic [TAG_IDX_W-1:0] k,
                                          input logic [TAG_IDX_W-1:0] n);
        logic [1:0] t;
        if (n == TAG_IDX_W'(1)) begin
            t = TAG_SINGLE;
        end else if (k == '0) begin
            t = TAG_FIRST;
        end else if (k == n - TAG_IDX_W'(1)) begin
            t = TAG_LAST;
        end else begin
            t = TAG_MID;
        end
        return t;
    endfunction

endpackage

// File: rtl/ifmap_row_framer.sv
// ---------------------------------------------------------------------------
// ifmap_row_framer
// Frames a raw pixel stream into tagged IF buffer words {tag, data}, with
// optional zero padding before and after each row.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous reset, active low
//   start    - one-cycle pulse; latches row_len/pad_len (only honoured in IDLE)
//   row_len  - number of stream pixels in the row
//   pad_len  - zero words inserted before and after the row
//   s_valid  - upstream pixel valid
//   s_data   - upstream pixel
//   s_ready  - framer accepts s_data this cycle
//   IF_wen   - IF buffer write strobe
//   IF_din   - {tag, data} written to the IF buffer
//   IF_full  - IF buffer full
//   busy     - row in progress (PRE/DATA/POST)
//   done     - one-cycle pulse after the last word of the frame
// ---------------------------------------------------------------------------
module ifmap_row_framer
    import ifmap_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ROW_LEN_W = 6,
    parameter int PAD_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_LEN_W-1:0] row_len,
    input  logic [PAD_W-1:0]     pad_len,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 s_ready,
    output logic                 IF_wen,
    output logic [DATA_W+1:0]    IF_din,
    input  logic                 IF_full,
    output logic                 busy,
    output logic                 done
);

    // Wide enough for row_len + 2*pad_len at their maxima.
    localparam int K_W = ROW_LEN_W + PAD_W + 1;

    state_e               state_q,   state_d;
    logic [ROW_LEN_W-1:0] row_len_q, row_len_d;
    logic [PAD_W-1:0]     pad_len_q, pad_len_d;
    logic [K_W-1:0]       phase_q,   phase_d;
    logic [K_W-1:0]       k_q,       k_d;

    logic [K_W-1:0]       n_cur;
    logic [K_W-1:0]       n_start;
    logic                 pad_last;
    logic                 row_last;
    logic [1:0]           word_tag;

    assign n_cur    = K_W'(row_len_q) + (K_W'(pad_len_q) << 1);
    assign n_start  = K_W'(row_len) + (K_W'(pad_len) << 1);
    assign pad_last = (phase_q == K_W'(pad_len_q) - K_W'(1));
    assign row_last = (phase_q == K_W'(row_len_q) - K_W'(1));
    assign word_tag = tag_of(TAG_IDX_W'(k_q), TAG_IDX_W'(n_cur));

    // phase_q counts words within the current PRE/DATA/POST phase,
    // k_q counts words across the whole frame and selects the tag.
    // Both only move when a word is actually written, so IF_full
    // stalls everything without losing position.
    always_comb begin
        state_d   = state_q;
        row_len_d = row_len_q;
        pad_len_d = pad_len_q;
        phase_d   = phase_q;
        k_d       = k_q;
        s_ready   = 1'b0;
        IF_wen    = 1'b0;
        IF_din    = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_len_d = row_len;
                    pad_len_d = pad_len;
                    phase_d   = '0;
                    k_d       = '0;
                    if (n_start == '0) begin
                        state_d = DONE;
                    end else if (pad_len != '0) begin
                        state_d = PRE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            PRE: begin
                busy   = 1'b1;
                IF_wen = ~IF_full;
                IF_din = {word_tag, {DATA_W{1'b0}}};
                if (IF_wen) begin
                    k_d = k_q + K_W'(1);
                    if (pad_last) begin
                        phase_d = '0;
                        // A pad-only frame skips straight to trailing pad.
                        state_d = (row_len_q == '0) ? POST : DATA;
                    end else begin
                        phase_d = phase_q + K_W'(1);
                    end
                end
            end

            DATA: begin
                busy    = 1'b1;
                s_ready = ~IF_full;
                IF_wen  = s_valid & ~IF_full;
                IF_din  = {word_tag, s_data};
                if (IF_wen) begin
                    k_d = k_q + K_W'(1);
                    if (row_last) begin
                        phase_d = '0;
                        state_d = (pad_len_q != '0) ? POST : DONE;
                    end else begin
                        phase_d = phase_q + K_W'(1);
                    end
                end
            end

            POST: begin
                busy   = 1'b1;
                IF_wen = ~IF_full;
                IF_din = {word_tag, {DATA_W{1'b0}}};
                if (IF_wen) begin
                    k_d = k_q + K_W'(1);
                    if (pad_last) begin
                        phase_d = '0;
                        state_d = DONE;
                    end else begin
                        phase_d = phase_q + K_W'(1);
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any partial row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_len_q <= '0;
            pad_len_q <= '0;
            phase_q   <= '0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            row_len_q <= row_len_d;
            pad_len_q <= pad_len_d;
            phase_q   <= phase_d;
            k_q       <= k_d;
        end
    end

endmodule

// File: doc/ifmap_row_framer.md
Name: ifmap_row_framer

Overview:
Upstream feeder for the convolution core's IFmap buffer. It accepts a raw 16-bit pixel stream over a valid/ready handshake. Each row is framed into 18-bit words {tag[1:0], data[15:0]}, with optional zero padding at both ends. Words are pushed into the IF buffer through its wen/full interface, so the software/testbench no longer hand-builds the start/end tag bits.

Parameters:
DATA_W, 16, pixel width; IF_din is DATA_W+2 bits
ROW_LEN_W, 6, width of row_len (max row 63, matches IF_BUFFER_DEPTH 64)
PAD_W, 2, width of pad_len (0..3 zeros each side)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse; latches row_len/pad_len; ignored unless IDLE
row_len  in  ROW_LEN_W  number of stream pixels in the row
pad_len  in  PAD_W  zeros inserted before and after the row
s_valid  in  1  upstream pixel valid
s_data  in  DATA_W  upstream pixel (two's complement)
s_ready  out  1  framer accepts s_data this cycle
IF_wen  out  1  write strobe to IF buffer
IF_din  out  DATA_W+2  {tag, data} to IF buffer
IF_full  in  1  IF buffer full
busy  out  1  row in progress
done  out  1  one-cycle pulse after last word written

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counters 0, latched lengths 0; s_ready=0, IF_wen=0, IF_din=0, busy=0, done=0.
- Tags: first word of the frame = 2'b10; middle words = 2'b00; last word = 2'b01; a frame of exactly one word = 2'b11.
- Frame length: N = row_len + 2*pad_len. The word index k runs 0..N-1 and drives the tag.
- States:
  - IDLE: start & N>0 -> PRE if pad_len>0, else DATA. start & N==0 -> DONE with no writes.
  - PRE: emits pad_len zero words -> DATA, or POST if row_len==0.
  - DATA: emits row_len stream words -> POST if pad_len>0, else DONE.
  - POST: emits pad_len zero words -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Write rule is combinational, zero latency:
  - PRE/POST: IF_wen = ~IF_full; IF_din = {tag, 0}.
  - DATA: s_ready = ~IF_full; IF_wen = s_valid & ~IF_full; IF_din = {tag, s_data}.
  - IDLE/DONE: IF_wen = 0, s_ready = 0.
- Counters advance only on IF_wen=1. While IF_full=1 nothing advances and IF_din may change freely.
- busy = 1 in PRE, DATA and POST.
- start while busy or in DONE: ignored; latched lengths are unchanged.
- Reset mid-row: the partial row is abandoned with no further writes. Flushing the IF buffer is the core's responsibility.
- Row/stream mismatch: extra stream pixels stay blocked (s_ready=0) until the next row. Fewer pixels stall the framer in DATA indefinitely; no timeout.
- s_valid and IF_full are treated as independent every cycle. A beat completes only when valid & ready.

Decomposition:
- Shared package ifmap_pkg holds:
  - tag constants TAG_FIRST=2'b10, TAG_MID=2'b00, TAG_LAST=2'b01, TAG_SINGLE=2'b11;
  - state encoding IDLE/PRE/DATA/POST/DONE;
  - a tag function of (k, N).
- No sub-module. The FSM, two counters (phase count, global index k) and tag mux live in one module of about 150-200 lines.

Test Plan:
- Basic row: row_len=10, pad_len=0, stream 19,-16,17,-65,34,-32,13,-34,21,-5, IF_full=0.
  - Expect 10 writes: {10,19}, eight {00,x}, {01,-5}; done one cycle after the last write.
- Padding: row_len=3, pad_len=1, stream 5,6,7.
  - Expect 5 writes: {10,0}, {00,5}, {00,6}, {00,7}, {01,0}.
- Backpressure: row_len=4; IF_full high for 3 cycles after the second write.
  - Expect IF_wen=0 and s_ready=0 for those cycles; no word lost or duplicated; 4 correct writes in total.
- Single word: row_len=1, pad_len=0, s_data=-42.
  - Expect one write {11,-42}, then done.
- Reset mid-row: assert rst low after 2 of 6 words.
  - Expect all outputs 0 immediately and state IDLE; a new start with row_len=2 produces {10,a}, {01,b}.
- Start while busy, plus row_len=0 with pad_len=0:
  - Second start is ignored and the original frame completes intact.
  - Zero-length start gives done with no IF_wen.
